player_ctrl: RTL and testbench

Per-player game-state engine: once per video frame it converts debounced button levels into player position, jump arc, pose (normal/squat/shield), HP and a single in-flight bullet. It writes the object state that the pixel compositor reads (ObjectID plus coordinates), using the movement, jump, HP and bullet constants of `gamepkg`. Two instances exist, one per player, distinguished by parameters.

---
 rtl/gamepkg.sv | 47 ++++
 rtl/player_bullet.sv | 67 ++++++
 rtl/player_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_player_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gamepkg.sv
// Shared game constants, object IDs and player-state types used by the player
// engine and the pixel compositor.
package gamepkg;

    localparam int COORD_W = 12;
    localparam int HP_W    = 7;

    localparam int STEP_X        = 5;
    localparam int JUMP_V        = 10;
    localparam int JUMP_G        = 1;
    localparam int MAX_J         = 20;
    localparam int MAX_HP        = 100;
    localparam int LIMIT_X       = 10;
    localparam int BULLET_STEP_X = 11;

    typedef enum logic [3:0] {
        OBJECT_NONE,
        OBJECT_PLAYER1,
        OBJECT_PLAYER1_SQUAT,
        OBJECT_PLAYER1_SHIELD,
        OBJECT_BULLET1,
        OBJECT_PLAYER2,
        OBJECT_PLAYER2_SQUAT,
        OBJECT_PLAYER2_SHIELD,
        OBJECT_BULLET2
    } ObjectID;

    typedef enum logic [1:0] {StIdle, StGround, StAir, StDead} PlayerState;

    typedef enum logic [1:0] {PoseNormal, PoseSquat, PoseShield} Pose;

    function automatic ObjectID player_obj(input int pid, input Pose p);
        ObjectID o;
        o = OBJECT_NONE;
        unique case (p)
            PoseSquat:  o = (pid == 2) ? OBJECT_PLAYER2_SQUAT : OBJECT_PLAYER1_SQUAT;
            PoseShield: o = (pid == 2) ? OBJECT_PLAYER2_SHIELD : OBJECT_PLAYER1_SHIELD;
            default:    o = (pid == 2) ? OBJECT_PLAYER2 : OBJECT_PLAYER1;
        endcase
        return o;
    endfunction

    function automatic ObjectID bullet_obj(input int pid);
        return (pid == 2) ? OBJECT_BULLET2 : OBJECT_BULLET1;
    endfunction

endpackage

// File: rtl/player_bullet.sv
// Single in-flight bullet: spawns on request, advances once per frame tick and
// disappears when it leaves the playfield or is consumed by the opponent.
module player_bullet
    import gamepkg::*;
#(
    parameter int FACING = 1,
    parameter int X_MIN  = -620,
    parameter int X_MAX  = 620
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic                      tick_i,
    input  logic                      hit_i,
    input  logic                      spawn_i,
    input  logic signed [COORD_W-1:0] spawn_x_i,
    input  logic signed [COORD_W-1:0] spawn_y_i,
    output logic                      valid_o,
    output logic signed [COORD_W-1:0] x_o,
    output logic signed [COORD_W-1:0] y_o
);

    logic                      valid_q, valid_d;
    logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [COORD_W:0]   nx;

    assign nx = COORD_W'(x_q) + (COORD_W + 1)'(FACING * BULLET_STEP_X);

    always_comb begin
        valid_d = valid_q;
        x_d     = x_q;
        y_d     = y_q;
        // A hit from the opponent wins over any movement in the same cycle.
        if (clear_i || hit_i) begin
            valid_d = 1'b0;
        end else if (tick_i) begin
            if (valid_q) begin
                if (nx < (COORD_W + 1)'(X_MIN) || nx > (COORD_W + 1)'(X_MAX)) begin
                    valid_d = 1'b0;
                end else begin
                    x_d = nx[COORD_W-1:0];
                end
            end else if (spawn_i) begin
                valid_d = 1'b1;
                x_d     = spawn_x_i;
                y_d     = spawn_y_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= valid_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    assign valid_o = valid_q;
    assign x_o     = x_q;
    assign y_o     = y_q;

endmodule

// File: rtl/player_ctrl.sv
// Per-player game-state engine: per frame tick converts button levels into
// position, jump arc, pose, HP and a single bullet for the compositor.
module player_ctrl
    import gamepkg::*;
#(
    parameter int PLAYER_ID = 1,
    parameter int FACING    = 1,
    parameter int INIT_X    = -500,
    parameter int GROUND_Y  = -300,
    parameter int X_MIN     = -620,
    parameter int X_MAX     = 620
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_frame_tick,
    input  logic                      i_game_active,
    input  logic                      i_left,
    input  logic                      i_right,
    input  logic                      i_jump,
    input  logic                      i_squat,
    input  logic                      i_shield,
    input  logic                      i_fire,
    input  logic                      i_hit,
    input  logic [HP_W-1:0]           i_dmg,
    input  logic                      i_bullet_hit,
    output logic signed [COORD_W-1:0] o_x,
    output logic signed [COORD_W-1:0] o_y,
    output ObjectID                   o_obj,
    output logic [HP_W-1:0]           o_hp,
    output logic                      o_dead,
    output logic                      o_bullet_valid,
    output logic signed [COORD_W-1:0] o_bullet_x,
    output logic signed [COORD_W-1:0] o_bullet_y,
    output ObjectID                   o_bullet_obj
);

    PlayerState                state_q, state_d;
    Pose                       pose_q, pose_d, pose_new;
    logic signed [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic signed [7:0]         vy_q, vy_d;
    logic [4:0]                j_q, j_d;
    logic [HP_W-1:0]           hp_q, hp_d;
    logic                      fire_prev_q, req_q, req_d;
    logic                      spawn, bullet_valid;
    logic signed [COORD_W:0]   nx, ny, spawn_sum;
    logic [HP_W:0]             hp_diff;

    assign spawn_sum = COORD_W'(x_q) + (COORD_W + 1)'(FACING * LIMIT_X);

    always_comb begin
        state_d  = state_q;
        pose_d   = pose_q;
        pose_new = pose_q;
        x_d      = x_q;
        y_d      = y_q;
        vy_d     = vy_q;
        j_d      = j_q;
        hp_d     = hp_q;
        spawn    = 1'b0;
        nx       = COORD_W'(x_q);
        ny       = COORD_W'(y_q);
        hp_diff  = {1'b0, hp_q} - {1'b0, i_dmg};
        // A fire edge on a tick cycle is held for the following tick.
        req_d    = (req_q & ~i_frame_tick) | (i_fire & ~fire_prev_q);

        if (!i_game_active) begin
            state_d = StIdle;
            pose_d  = PoseNormal;
            x_d     = COORD_W'(INIT_X);
            y_d     = COORD_W'(GROUND_Y);
            vy_d    = '0;
            j_d     = '0;
            hp_d    = HP_W'(MAX_HP);
            req_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: state_d = StGround;
                StGround, StAir: begin
                    if (i_frame_tick) begin
                        if (state_q == StGround) begin
                            pose_new = i_shield ? PoseShield : (i_squat ? PoseSquat : PoseNormal);
                        end else begin
                            pose_new = PoseNormal;
                        end
                        pose_d = pose_new;

                        if (pose_new == PoseNormal && (i_left ^ i_right)) begin
                            nx = i_left ? COORD_W'(x_q) - (COORD_W + 1)'(STEP_X)
                                        : COORD_W'(x_q) + (COORD_W + 1)'(STEP_X);
                            if (nx < (COORD_W + 1)'(X_MIN)) begin
                                x_d = COORD_W'(X_MIN);
                            end else if (nx > (COORD_W + 1)'(X_MAX)) begin
                                x_d = COORD_W'(X_MAX);
                            end else begin
                                x_d = nx[COORD_W-1:0];
                            end
                        end

                        if (state_q == StAir) begin
                            if (j_q + 5'd1 < 5'(MAX_J)) begin
                                ny   = COORD_W'(y_q) + (COORD_W + 1)'(vy_q);
                                y_d  = ny[COORD_W-1:0];
                                vy_d = vy_q - 8'(JUMP_G);
                                j_d  = j_q + 5'd1;
                            end else begin
                                y_d     = COORD_W'(GROUND_Y);
                                vy_d    = '0;
                                j_d     = '0;
                                state_d = StGround;
                            end
                        end else if (i_jump && pose_new == PoseNormal) begin
                            state_d = StAir;
                            vy_d    = 8'(JUMP_V);
                            j_d     = '0;
                        end

                        spawn = req_q & ~bullet_valid & (pose_new != PoseShield);
                    end

                    // Damage is judged against the pose held before this cycle.
                    if (i_hit && pose_q != PoseShield) begin
                        hp_d = hp_diff[HP_W] ? '0 : hp_diff[HP_W-1:0];
                        if (hp_d == '0) begin
                            state_d = StDead;
                            pose_d  = PoseNormal;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            pose_q      <= PoseNormal;
            x_q         <= COORD_W'(INIT_X);
            y_q         <= COORD_W'(GROUND_Y);
            vy_q        <= '0;
            j_q         <= '0;
            hp_q        <= HP_W'(MAX_HP);
            fire_prev_q <= 1'b0;
            req_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pose_q      <= pose_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            j_q         <= j_d;
            hp_q        <= hp_d;
            fire_prev_q <= i_fire;
            req_q       <= req_d;
        end
    end

    player_bullet #(
        .FACING(FACING),
        .X_MIN (X_MIN),
        .X_MAX (X_MAX)
    ) u_bullet (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .clear_i  (~i_game_active),
        .tick_i   (i_frame_tick),
        .hit_i    (i_bullet_hit),
        .spawn_i  (spawn),
        .spawn_x_i(spawn_sum[COORD_W-1:0]),
        .spawn_y_i(y_q),
        .valid_o  (bullet_valid),
        .x_o      (o_bullet_x),
        .y_o      (o_bullet_y)
    );

    assign o_x            = x_q;
    assign o_y            = y_q;
    assign o_obj          = player_obj(PLAYER_ID, pose_q);
    assign o_hp           = hp_q;
    assign o_dead         = (state_q == StDead);
    assign o_bullet_valid = bullet_valid;
    assign o_bullet_obj   = bullet_obj(PLAYER_ID);

endmodule

// File: tb/tb_player_ctrl.sv
// Bench for player_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a behavioural model of the player rules.
module tb_player_ctrl;
    import gamepkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0, tick = 1'b0, active = 1'b0;
    logic left = 1'b0, right = 1'b0, jump = 1'b0, squat = 1'b0, shield = 1'b0, fire = 1'b0;
    logic hit = 1'b0, bhit = 1'b0;
    logic [6:0] dmg = '0;
    logic signed [11:0] o_x, o_y, o_bx, o_by;
    ObjectID o_obj, o_bobj;
    logic [6:0] o_hp;
    logic o_dead, o_bv;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: plain flags and integers, not the design's encoding.
    bit m_idle, m_air, m_dead, m_bv, m_req, m_fprev;
    int m_x, m_y, m_hp, m_k, m_pose, m_bx, m_by;   // m_pose: 0 normal, 1 squat, 2 shield
    int arc[20] = '{10, 19, 27, 34, 40, 45, 49, 52, 54, 55, 55, 54, 52, 49, 45, 40, 34, 27, 19, 0};

    always #5 clk = ~clk;

    player_ctrl dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_frame_tick  (tick),
        .i_game_active (active),
        .i_left        (left),
        .i_right       (right),
        .i_jump        (jump),
        .i_squat       (squat),
        .i_shield      (shield),
        .i_fire        (fire),
        .i_hit         (hit),
        .i_dmg         (dmg),
        .i_bullet_hit  (bhit),
        .o_x           (o_x),
        .o_y           (o_y),
        .o_obj         (o_obj),
        .o_hp          (o_hp),
        .o_dead        (o_dead),
        .o_bullet_valid(o_bv),
        .o_bullet_x    (o_bx),
        .o_bullet_y    (o_by),
        .o_bullet_obj  (o_bobj)
    );

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int arc_off(input int k);
        return k * 10 - (k * (k - 1)) / 2;
    endfunction

    task automatic model_idle();
        m_idle = 1; m_air = 0; m_dead = 0; m_bv = 0; m_req = 0;
        m_x = -500; m_y = -300; m_hp = 100; m_k = 0; m_pose = 0;
    endtask

    task automatic model_cycle();
        bit edge_f, spawn, old_bv;
        int old_x, old_y, old_pose, nb;
        edge_f = fire && !m_fprev;
        if (rst) begin
            model_idle();
            m_fprev = 0;
            return;
        end
        m_fprev = fire;
        if (!active) begin
            model_idle();
            return;
        end
        old_bv = m_bv; old_x = m_x; old_y = m_y; old_pose = m_pose;
        spawn = 0;
        if (m_idle) begin
            m_idle = 0;
        end else if (!m_dead) begin
            if (tick) begin
                m_pose = m_air ? 0 : (shield ? 2 : (squat ? 1 : 0));
                if (m_pose == 0 && left != right) begin
                    m_x = m_x + (right ? 5 : -5);
                    if (m_x > 620) m_x = 620;
                    if (m_x < -620) m_x = -620;
                end
                if (m_air) begin
                    if (m_k + 1 < 20) begin
                        m_k++;
                        m_y = -300 + arc_off(m_k);
                    end else begin
                        m_air = 0; m_k = 0; m_y = -300;
                    end
                end else if (jump && m_pose == 0) begin
                    m_air = 1; m_k = 0;
                end
                spawn = m_req && !old_bv && m_pose != 2;
            end
            if (hit && old_pose != 2) begin
                m_hp = (m_hp > int'(dmg)) ? m_hp - int'(dmg) : 0;
                if (m_hp == 0) begin
                    m_dead = 1; m_air = 0; m_pose = 0;
                end
            end
        end
        m_req = (tick ? 1'b0 : m_req) | edge_f;
        if (bhit) begin
            m_bv = 0;
        end else if (tick) begin
            if (old_bv) begin
                nb = m_bx + 11;
                if (nb > 620 || nb < -620) m_bv = 0;
                else m_bx = nb;
            end else if (spawn) begin
                m_bv = 1; m_bx = old_x + 10; m_by = old_y;
            end
        end
    endtask

    task automatic compare_all();
        ObjectID eo;
        eo = (m_pose == 2) ? OBJECT_PLAYER1_SHIELD : (m_pose == 1) ? OBJECT_PLAYER1_SQUAT
                                                                   : OBJECT_PLAYER1;
        check_eq("x", int'(o_x), m_x);
        check_eq("y", int'(o_y), m_y);
        check_eq("obj", int'(o_obj), int'(eo));
        check_eq("hp", int'(o_hp), m_hp);
        check_eq("dead", int'(o_dead), int'(m_dead));
        check_eq("bvalid", int'(o_bv), int'(m_bv));
        check_eq("bobj", int'(o_bobj), int'(OBJECT_BULLET1));
        if (m_bv) begin
            check_eq("bx", int'(o_bx), m_bx);
            check_eq("by", int'(o_by), m_by);
        end
    endtask

    task automatic step();
        model_cycle();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_fire();
        fire = 1'b1;
        step();
        fire = 1'b0;
    endtask

    task automatic pulse_hit(input int amount);
        hit = 1'b1;
        dmg = 7'(amount);
        step();
        hit = 1'b0;
    endtask

    initial begin
        int x_saved;
        m_fprev = 0; m_bx = 0; m_by = 0;
        model_idle();
        #1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        active = 1'b1;
        step();
        check_eq("init_x", int'(o_x), -500);
        check_eq("init_y", int'(o_y), -300);
        check_eq("init_hp", int'(o_hp), 100);
        check_eq("init_obj", int'(o_obj), int'(OBJECT_PLAYER1));
        check_eq("init_bv", int'(o_bv), 0);

        // Fire, ignored re-fire, opponent consume, re-spawn.
        pulse_fire();
        do_tick();
        check_eq("spawn_x", int'(o_bx), -490);
        do_tick();
        check_eq("move_x", int'(o_bx), -479);
        pulse_fire();
        do_tick();
        check_eq("refire_ignored", int'(o_bx), -468);
        bhit = 1'b1;
        step();
        bhit = 1'b0;
        check_eq("bhit_clear", int'(o_bv), 0);
        pulse_fire();
        do_tick();
        check_eq("respawn", int'(o_bx), -490);

        // Walk right into the clamp, then press both directions.
        right = 1'b1;
        repeat (230) do_tick();
        check_eq("clamp_x", int'(o_x), 620);
        left = 1'b1;
        do_tick();
        check_eq("both_x", int'(o_x), 620);
        left = 1'b0; right = 1'b0;

        // Full jump arc with squat pressed mid-air.
        jump = 1'b1;
        do_tick();
        jump = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (k == 5) squat = 1'b1;
            do_tick();
            check_eq("arc_y", int'(o_y), -300 + arc[k]);
            check_eq("air_obj", int'(o_obj), int'(OBJECT_PLAYER1));
        end
        squat = 1'b0;

        // Shield blocks damage; unshielded hits kill.
        shield = 1'b1;
        do_tick();
        pulse_hit(30);
        check_eq("shield_hp", int'(o_hp), 100);
        shield = 1'b0;
        do_tick();
        pulse_hit(60);
        check_eq("hp_40", int'(o_hp), 40);
        pulse_hit(60);
        check_eq("hp_0", int'(o_hp), 0);
        check_eq("dead", int'(o_dead), 1);
        x_saved = int'(o_x);
        left = 1'b1;
        do_tick();
        check_eq("dead_frozen", int'(o_x), x_saved);
        left = 1'b0;

        // Revive, then reset mid-jump with a bullet in flight.
        active = 1'b0;
        step();
        active = 1'b1;
        step();
        pulse_fire();
        jump = 1'b1;
        do_tick();
        jump = 1'b0;
        do_tick();
        do_tick();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_x", int'(o_x), -500);
        check_eq("rst_y", int'(o_y), -300);
        check_eq("rst_hp", int'(o_hp), 100);
        check_eq("rst_bv", int'(o_bv), 0);
        check_eq("rst_dead", int'(o_dead), 0);

        for (int i = 0; i < 4000; i++) begin
            rst    = ($urandom_range(0, 499) == 0);
            active = ($urandom_range(0, 149) != 0);
            tick   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) {left, right, jump, squat, shield, fire} = 6'($urandom);
            hit  = ($urandom_range(0, 19) == 0);
            dmg  = 7'($urandom_range(0, 40));
            bhit = ($urandom_range(0, 29) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
